// File: rtl/frequency_meter.sv
// Frequency meter: measures the period and high time of an asynchronous input in
// system clock cycles, reports lock on stable periods and timeout on a stalled input.
module frequency_meter #(
    parameter int TIMEOUT   = 500000,
    parameter int TOLERANCE = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sig_in,
    output logic [18:0] period,
    output logic [18:0] high_time,
    output logic        valid,
    output logic        locked,
    output logic        timeout
);

    localparam logic [18:0]        CNT_MAX = 19'(TIMEOUT - 1);
    localparam logic signed [19:0] TOL     = 20'(TOLERANCE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        STALLED = 2'd3
    } state_t;

    // state_q is the observation point for external checkers.
    state_t state_q, state_d;

    logic               s1, s2, s3;
    logic               rise, fall;
    logic               counting, at_limit;
    logic [18:0]        cnt, hcnt, cnt_inc;
    logic               hcnt_run;
    logic signed [19:0] diff, abs_diff;
    logic               in_tol;
    logic               meas_stb, meas_lock_upd, meas_lock;
    logic [18:0]        meas_period, meas_high;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign counting = (state_q == ARMED) || (state_q == MEASURE);
    assign at_limit = counting && (cnt == CNT_MAX) && !rise;
    assign cnt_inc  = cnt + 19'd1;

    // period still holds the previous measurement when the next rise is processed.
    assign diff     = $signed({1'b0, cnt_inc}) - $signed({1'b0, period});
    assign abs_diff = diff[19] ? (20'sd0 - diff) : diff;
    assign in_tol   = (abs_diff <= TOL);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rise) state_d = ARMED;
            end
            ARMED, MEASURE: begin
                if (rise)          state_d = MEASURE;
                else if (at_limit) state_d = STALLED;
            end
            STALLED: begin
                if (rise) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    // The rise cycle is itself the first high cycle, so hcnt restarts at 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= 19'd0;
            hcnt     <= 19'd0;
            hcnt_run <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt <= 19'd0;
                    if (rise) begin
                        hcnt     <= 19'd1;
                        hcnt_run <= 1'b1;
                    end else begin
                        hcnt     <= 19'd0;
                        hcnt_run <= 1'b0;
                    end
                end
                ARMED, MEASURE: begin
                    if (rise) begin
                        cnt      <= 19'd0;
                        hcnt     <= 19'd1;
                        hcnt_run <= 1'b1;
                    end else begin
                        if (cnt != CNT_MAX) cnt <= cnt_inc;
                        if (fall)          hcnt_run <= 1'b0;
                        else if (hcnt_run) hcnt     <= hcnt + 19'd1;
                    end
                end
                STALLED: begin
                    if (rise) begin
                        cnt      <= 19'd0;
                        hcnt     <= 19'd1;
                        hcnt_run <= 1'b1;
                    end
                end
                default: begin
                    cnt      <= 19'd0;
                    hcnt     <= 19'd0;
                    hcnt_run <= 1'b0;
                end
            endcase
        end
    end

    // Measurement capture stage; the output stage below publishes it one edge later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meas_stb      <= 1'b0;
            meas_lock_upd <= 1'b0;
            meas_lock     <= 1'b0;
            meas_period   <= 19'd0;
            meas_high     <= 19'd0;
        end else begin
            meas_stb      <= counting && rise;
            meas_lock_upd <= (state_q == MEASURE) && rise;
            if (counting && rise) begin
                meas_period <= cnt_inc;
                meas_high   <= hcnt;
                meas_lock   <= in_tol;
            end
        end
    end

    // valid is a single-cycle strobe with no back-pressure: period, high_time and
    // locked are coherent in the cycle valid is high and hold until the next strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            period    <= 19'd0;
            high_time <= 19'd0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= meas_stb;
            if (meas_stb) begin
                period    <= meas_period;
                high_time <= meas_high;
                if (meas_lock_upd) locked <= meas_lock;
            end
            if (at_limit) begin
                timeout <= 1'b1;
                locked  <= 1'b0;
            end else if ((state_q == STALLED) && rise) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frequency_meter.sv
// Testbench for frequency_meter: waveform tables of sig_in checked cycle by cycle
// against a reference model derived from the rise-to-rise timing of the waveform.
module tb_frequency_meter;

  localparam int T    = 100;
  localparam int TOL  = 2;
  localparam int MAXN = 3200;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        sig_in  = 1'b0;
  logic [18:0] period;
  logic [18:0] high_time;
  logic        valid;
  logic        locked;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  bit wave[MAXN];
  int wlen;

  bit e_valid[MAXN];
  bit e_locked[MAXN];
  bit e_timeout[MAXN];
  int ev_lock[MAXN];
  int ev_to[MAXN];

  logic [37:0] exp_q[$];
  logic [31:0] cur_period;
  logic [31:0] cur_high;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  frequency_meter #(
    .TIMEOUT  (T),
    .TOLERANCE(TOL)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .locked   (locked),
    .timeout  (timeout)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- waveform builders ----------------
  task automatic add_pulses(input int p, input int h, input int count);
    for (int n = 0; n < count; n++) begin
      for (int j = 0; j < p; j++) begin
        if (wlen < MAXN) begin
          wave[wlen] = (j < h);
          wlen++;
        end
      end
    end
  endtask

  task automatic add_low(input int n);
    for (int j = 0; j < n; j++) begin
      if (wlen < MAXN) begin
        wave[wlen] = 1'b0;
        wlen++;
      end
    end
  endtask

  // ---------------- reference model ----------------
  // A rise sampled at edge k yields a strobe at edge k+3.  Rises no more than T
  // edges apart form a measurement; a longer gap stalls T+2 edges after the last
  // rise, and the rise that ends the stall (seen at edge k+2) only re-arms.
  task automatic build_model();
    int  rises[$];
    bit  prev;
    bit  have_meas;
    int  prev_gap;
    int  gap;
    int  ones;
    int  d;
    int  k;
    bit  cur_lock;
    bit  cur_to;
    exp_q.delete();
    prev = 1'b0;
    for (int c = 0; c < wlen; c++) begin
      if (wave[c] && !prev) rises.push_back(c);
      prev = wave[c];
      e_valid[c] = 1'b0;
      ev_lock[c] = -1;
      ev_to[c]   = -1;
    end
    have_meas = 1'b0;
    prev_gap  = 0;
    for (int i = 1; i < rises.size(); i++) begin
      k   = rises[i];
      gap = k - rises[i-1];
      if (gap <= T) begin
        ones = 0;
        for (int j = rises[i-1]; j < k; j++) ones += int'(wave[j]);
        if (k + 3 < wlen) begin
          e_valid[k+3] = 1'b1;
          exp_q.push_back({19'(gap), 19'(ones)});
          if (have_meas) begin
            d = gap - prev_gap;
            if (d < 0) d = -d;
            ev_lock[k+3] = (d <= TOL) ? 1 : 0;
          end
        end
        have_meas = 1'b1;
        prev_gap  = gap;
      end else begin
        if (rises[i-1] + T + 2 < wlen) begin
          ev_to[rises[i-1] + T + 2]   = 1;
          ev_lock[rises[i-1] + T + 2] = 0;
        end
        if (k + 2 < wlen) ev_to[k+2] = 0;
        have_meas = 1'b0;
      end
    end
    if (rises.size() > 0) begin
      k = rises[rises.size()-1];
      if (k + T + 2 < wlen) begin
        ev_to[k+T+2]   = 1;
        ev_lock[k+T+2] = 0;
      end
    end
    cur_lock = 1'b0;
    cur_to   = 1'b0;
    for (int c = 0; c < wlen; c++) begin
      if (ev_lock[c] >= 0) cur_lock = (ev_lock[c] == 1);
      if (ev_to[c] >= 0)   cur_to   = (ev_to[c] == 1);
      e_locked[c]  = cur_lock;
      e_timeout[c] = cur_to;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_phase(input string name);
    logic [37:0] e;
    build_model();
    @(negedge clock);
    reset_n = 1'b0;
    sig_in  = 1'b0;
    repeat (3) @(negedge clock);
    check({name, " rst period"},    32'(period),    32'd0);
    check({name, " rst high_time"}, 32'(high_time), 32'd0);
    check({name, " rst valid"},     32'(valid),     32'd0);
    check({name, " rst locked"},    32'(locked),    32'd0);
    check({name, " rst timeout"},   32'(timeout),   32'd0);
    cur_period = 32'd0;
    cur_high   = 32'd0;
    reset_n = 1'b1;
    for (int c = 0; c < wlen; c++) begin
      sig_in = wave[c];
      @(posedge clock);
      #1;
      check({name, " valid"},   32'(valid),   32'(e_valid[c]));
      check({name, " locked"},  32'(locked),  32'(e_locked[c]));
      check({name, " timeout"}, 32'(timeout), 32'(e_timeout[c]));
      if (e_valid[c] && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cur_period = 32'(e[37:19]);
        cur_high   = 32'(e[18:0]);
      end
      check({name, " period"},    32'(period),    cur_period);
      check({name, " high_time"}, 32'(high_time), cur_high);
      @(negedge clock);
    end
    check({name, " scoreboard drained"}, 32'(exp_q.size()), 32'd0);
    wlen = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p;
    int h;
    int cnt;
    wlen = 0;

    // 50/25 from reset, ending part-way into a period
    add_pulses(50, 25, 6);
    add_pulses(30, 25, 1);
    run_phase("p50");

    // asynchronous reset between clock edges clears outputs at once
    #2;
    reset_n = 1'b0;
    #1;
    check("async period",    32'(period),    32'd0);
    check("async high_time", 32'(high_time), 32'd0);
    check("async valid",     32'(valid),     32'd0);
    check("async locked",    32'(locked),    32'd0);
    check("async timeout",   32'(timeout),   32'd0);

    // minimum waveform
    add_pulses(2, 1, 40);
    add_low(4);
    run_phase("p2");

    // stall after stable period, then recovery
    add_pulses(50, 25, 4);
    add_low(150);
    add_pulses(50, 25, 3);
    add_low(5);
    run_phase("stall");

    // lock tracking across drifting periods
    add_pulses(50, 25, 2);
    add_pulses(52, 26, 1);
    add_pulses(55, 27, 1);
    add_pulses(20, 5, 1);
    run_phase("drift");

    // gap exactly TIMEOUT measures; one more cycle stalls
    add_pulses(T, 50, 3);
    add_pulses(T + 1, 50, 1);
    add_pulses(30, 10, 2);
    add_low(5);
    run_phase("limit");

    // randomized waveform
    while (wlen < 2400) begin
      if ($urandom_range(0, 9) == 0) p = $urandom_range(T + 1, T + 40);
      else                           p = $urandom_range(2, T);
      h   = $urandom_range(1, p - 1);
      cnt = $urandom_range(1, 4);
      add_pulses(p, h, cnt);
    end
    add_low(5);
    run_phase("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
